// File: rtl/mdv_pkg.sv
// Shared types and constants for the microdrive sector buffer.
// Used by mdv_sector_buf and mdv_buf_ram.
package mdv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_FILL  = 2'd2,
      ST_DRAIN = 2'd3
   } mdv_state_t;

   localparam logic [1:0] ACK_OFS_STATUS = 2'd0;
   localparam logic [1:0] ACK_OFS_LEN_LO = 2'd1;
   localparam logic [1:0] ACK_OFS_LEN_HI = 2'd2;

   localparam logic [7:0] ADDR_BUF_DEFAULT = 8'hF3;
   localparam logic [7:0] ADDR_ACK_DEFAULT = 8'hF4;

   localparam logic [7:0] REQ_READ_HEADER  = 8'h01;
   localparam logic [7:0] REQ_READ_SECTOR  = 8'h02;
   localparam logic [7:0] REQ_WRITE_SECTOR = 8'h03;

   // The ESP32 may announce more bytes than the buffer holds; only one buffer's worth is delivered.
   function automatic logic [16:0] clamp_len(input logic [15:0] len, input logic [16:0] depth);
      logic [16:0] len_ext;
      len_ext = {1'b0, len};
      return (len_ext > depth) ? depth : len_ext;
   endfunction

endpackage

// File: rtl/mdv_buf_ram.sv
// Inferred sector BRAM: one write port and one registered read port,
// plus a registered readback port for the ESP32 when MDV_WRITE_EN is defined.
module mdv_buf_ram
   import mdv_pkg::*;
#(
   parameter int C_BUF_BITS = 10
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [C_BUF_BITS-1:0] waddr,
   input  logic [7:0]            wdata,
   input  logic                  re,
   input  logic [C_BUF_BITS-1:0] raddr,
   output logic [7:0]            rdata
`ifdef MDV_WRITE_EN
   ,
   input  logic [C_BUF_BITS-1:0] rb_addr,
   output logic [7:0]            rb_data
`endif
);

   localparam int DEPTH = 2 ** C_BUF_BITS;

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (re) begin
         rdata <= mem[raddr];
      end
   end

`ifdef MDV_WRITE_EN
   always_ff @(posedge clk) begin
      rb_data <= mem[rb_addr];
   end
`endif

endmodule

// File: rtl/mdv_sector_buf.sv
// QL-side microdrive sector buffer: request pulse to the SPI slave, SPI fill, valid/pop drain.
// Define MDV_WRITE_EN to add the QL push path and ESP32 readback of the buffer.
module mdv_sector_buf
   import mdv_pkg::*;
#(
   parameter int         C_ADDR_BITS    = 32,
   parameter logic [7:0] C_ADDR_BUF     = ADDR_BUF_DEFAULT,
   parameter logic [7:0] C_ADDR_ACK     = ADDR_ACK_DEFAULT,
   parameter int         C_BUF_BITS     = 10,
   parameter int         C_TIMEOUT_BITS = 24
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   spi_wr,
   input  logic                   spi_rd,
   input  logic [C_ADDR_BITS-1:0] spi_addr,
   input  logic [7:0]             spi_wdata,
   output logic [7:0]             spi_rdata,
   output logic [7:0]             mdv_req_type,
   output logic                   mdv_req,
   input  logic                   ql_req,
   input  logic [7:0]             ql_req_type,
   output logic                   ql_busy,
   output logic [7:0]             ql_byte,
   output logic                   ql_byte_valid,
   input  logic                   ql_pop,
   output logic                   ql_done,
   output logic                   ql_error,
   input  logic                   ql_wr,
   input  logic [7:0]             ql_wdata
);

   localparam logic [16:0] DEPTH = 17'(2 ** C_BUF_BITS);

   mdv_state_t state, state_nxt;

   logic                      spi_wr_q;
   logic                      wr_evt;
   logic                      buf_hit;
   logic                      ack_hit;
   logic                      ack_evt;
   logic                      spi_buf_we;
   logic [1:0]                ack_ofs;
   logic [C_BUF_BITS-1:0]     spi_ofs;
   logic [7:0]                status_q;
   logic [7:0]                len_lo_q;
   logic [16:0]               len_clamped;
   logic [16:0]               len_m1;
   logic [C_TIMEOUT_BITS-1:0] tmo_cnt;
   logic [C_TIMEOUT_BITS-1:0] tmo_inc;
   logic                      tmo_fire;
   logic                      wr_ack;
   logic [C_BUF_BITS-1:0]     rd_ptr;
   logic [C_BUF_BITS-1:0]     rd_ptr_inc;
   logic [C_BUF_BITS-1:0]     last_idx;
   logic                      fetch_pend;
   logic                      fetch;
   logic                      valid_q;
   logic                      load_type;
   logic                      enter_drain;
   logic                      advance;
   logic                      ram_we;
   logic [C_BUF_BITS-1:0]     ram_waddr;
   logic [7:0]                ram_wdata;
   logic [7:0]                ram_rdata;

   assign wr_evt      = spi_wr & ~spi_wr_q;
   assign buf_hit     = (spi_addr[C_ADDR_BITS-1 -: 8] == C_ADDR_BUF);
   assign ack_hit     = (spi_addr[C_ADDR_BITS-1 -: 8] == C_ADDR_ACK);
   assign ack_evt     = (state == ST_FILL) && wr_evt && ack_hit;
   assign spi_buf_we  = (state == ST_FILL) && wr_evt && buf_hit;
   assign ack_ofs     = spi_addr[1:0];
   assign spi_ofs     = spi_addr[C_BUF_BITS-1:0];
   assign len_clamped = clamp_len({spi_wdata, len_lo_q}, DEPTH);
   assign len_m1      = len_clamped - 17'd1;
   assign tmo_inc     = tmo_cnt + {{(C_TIMEOUT_BITS-1){1'b0}}, 1'b1};
   assign tmo_fire    = tmo_inc[C_TIMEOUT_BITS-1];
   assign rd_ptr_inc  = rd_ptr + {{(C_BUF_BITS-1){1'b0}}, 1'b1};
   assign fetch       = (state == ST_DRAIN) && fetch_pend;

   assign ql_busy       = (state != ST_IDLE);
   assign ql_byte_valid = valid_q;
   assign ql_byte       = valid_q ? ram_rdata : 8'h00;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A completing ACK write outranks a timeout landing in the same cycle.
   always_comb begin
      state_nxt   = state;
      mdv_req     = 1'b0;
      ql_done     = 1'b0;
      ql_error    = 1'b0;
      load_type   = 1'b0;
      enter_drain = 1'b0;
      advance     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (ql_req) begin
               load_type = 1'b1;
               state_nxt = ST_REQ;
            end
         end
         ST_REQ: begin
            mdv_req   = 1'b1;
            state_nxt = ST_FILL;
         end
         ST_FILL: begin
            if (ack_evt && (ack_ofs == ACK_OFS_LEN_HI)) begin
               if (status_q != 8'h00) begin
                  ql_error  = 1'b1;
                  state_nxt = ST_IDLE;
               end else if (wr_ack || ({spi_wdata, len_lo_q} == 16'h0000)) begin
                  ql_done   = 1'b1;
                  state_nxt = ST_IDLE;
               end else begin
                  enter_drain = 1'b1;
                  state_nxt   = ST_DRAIN;
               end
            end else if (tmo_fire) begin
               ql_error  = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (ql_pop && valid_q) begin
               if (rd_ptr == last_idx) begin
                  ql_done   = 1'b1;
                  state_nxt = ST_IDLE;
               end else begin
                  advance = 1'b1;
               end
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         spi_wr_q     <= 1'b0;
         mdv_req_type <= 8'h00;
         tmo_cnt      <= '0;
         status_q     <= 8'h00;
         len_lo_q     <= 8'h00;
      end else begin
         spi_wr_q <= spi_wr;
         if (load_type) begin
            mdv_req_type <= ql_req_type;
         end
         if (state == ST_REQ) begin
            tmo_cnt  <= '0;
            status_q <= 8'h00;
            len_lo_q <= 8'h00;
         end else if (state == ST_FILL) begin
            tmo_cnt <= tmo_inc;
            if (ack_evt && (ack_ofs == ACK_OFS_STATUS)) begin
               status_q <= spi_wdata;
            end
            if (ack_evt && (ack_ofs == ACK_OFS_LEN_LO)) begin
               len_lo_q <= spi_wdata;
            end
         end
      end
   end

   // Each fetch is issued the cycle after a pop, so a byte is offered every second clock.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr     <= '0;
         last_idx   <= '0;
         fetch_pend <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         if (enter_drain) begin
            rd_ptr     <= '0;
            last_idx   <= len_m1[C_BUF_BITS-1:0];
            fetch_pend <= 1'b1;
         end else if (advance) begin
            rd_ptr     <= rd_ptr_inc;
            fetch_pend <= 1'b1;
         end else if (fetch) begin
            fetch_pend <= 1'b0;
         end
         if (state_nxt != ST_DRAIN) begin
            valid_q <= 1'b0;
         end else if (fetch) begin
            valid_q <= 1'b1;
         end else if (ql_pop && valid_q) begin
            valid_q <= 1'b0;
         end
      end
   end

`ifdef MDV_WRITE_EN
   logic [C_BUF_BITS-1:0] wr_ptr;
   logic                  ql_push;
   logic                  rb_sel_q;
   logic [7:0]            rb_data;

   assign ql_push   = (state == ST_IDLE) && ql_wr;
   assign wr_ack    = spi_wdata[7];
   assign ram_we    = spi_buf_we | ql_push;
   assign ram_waddr = ql_push ? wr_ptr : spi_ofs;
   assign ram_wdata = ql_push ? ql_wdata : spi_wdata;
   assign spi_rdata = rb_sel_q ? rb_data : 8'h00;

   // Pushes accumulate from offset 0 for each new request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rb_sel_q <= 1'b0;
      end else begin
         rb_sel_q <= buf_hit;
         if (load_type) begin
            wr_ptr <= '0;
         end else if (ql_push) begin
            wr_ptr <= wr_ptr + {{(C_BUF_BITS-1){1'b0}}, 1'b1};
         end
      end
   end
`else
   logic unused_wr_path;

   assign wr_ack         = 1'b0;
   assign ram_we         = spi_buf_we;
   assign ram_waddr      = spi_ofs;
   assign ram_wdata      = spi_wdata;
   assign spi_rdata      = 8'h00;
   assign unused_wr_path = ^{ql_wr, ql_wdata};
`endif

   logic unused_bits;
   assign unused_bits = ^{spi_rd, spi_addr[C_ADDR_BITS-9:C_BUF_BITS], len_m1[16:C_BUF_BITS]};

   mdv_buf_ram #(
      .C_BUF_BITS(C_BUF_BITS)
   ) u_ram (
      .clk    (clk),
      .we     (ram_we),
      .waddr  (ram_waddr),
      .wdata  (ram_wdata),
      .re     (fetch),
      .raddr  (rd_ptr),
      .rdata  (ram_rdata)
`ifdef MDV_WRITE_EN
      ,
      .rb_addr(spi_ofs),
      .rb_data(rb_data)
`endif
   );

endmodule

// File: tb/tb_mdv_sector_buf.sv
// Self-checking bench for mdv_sector_buf with a shortened FILL timeout (8 bits).
// Expected drain data comes from an array model of the buffer indexed by address modulo its depth.
module tb_mdv_sector_buf;

   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        spi_wr = 1'b0;
   logic        spi_rd = 1'b0;
   logic [31:0] spi_addr = 32'h0;
   logic [7:0]  spi_wdata = 8'h0;
   logic [7:0]  spi_rdata;
   logic [7:0]  mdv_req_type;
   logic        mdv_req;
   logic        ql_req = 1'b0;
   logic [7:0]  ql_req_type = 8'h0;
   logic        ql_busy;
   logic [7:0]  ql_byte;
   logic        ql_byte_valid;
   logic        ql_pop = 1'b0;
   logic        ql_done;
   logic        ql_error;
   logic        ql_wr = 1'b0;
   logic [7:0]  ql_wdata = 8'h0;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int n_req = 0;
   int n_done = 0;
   int n_err = 0;
   int n_valid = 0;
   int last_req_cyc = 0;
   int last_err_cyc = 0;
   logic [7:0] last_req_type = 8'h0;

   logic [7:0] model_mem [DEPTH];
   bit         model_known [DEPTH];
   logic [7:0] rx_q [$];

   mdv_sector_buf #(
      .C_TIMEOUT_BITS(8)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .spi_wr       (spi_wr),
      .spi_rd       (spi_rd),
      .spi_addr     (spi_addr),
      .spi_wdata    (spi_wdata),
      .spi_rdata    (spi_rdata),
      .mdv_req_type (mdv_req_type),
      .mdv_req      (mdv_req),
      .ql_req       (ql_req),
      .ql_req_type  (ql_req_type),
      .ql_busy      (ql_busy),
      .ql_byte      (ql_byte),
      .ql_byte_valid(ql_byte_valid),
      .ql_pop       (ql_pop),
      .ql_done      (ql_done),
      .ql_error     (ql_error),
      .ql_wr        (ql_wr),
      .ql_wdata     (ql_wdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse monitor sampled away from the active edge.
   always @(negedge clk) begin
      if (mdv_req) begin
         n_req = n_req + 1;
         last_req_cyc = cyc;
         last_req_type = mdv_req_type;
      end
      if (ql_done) n_done = n_done + 1;
      if (ql_error) begin
         n_err = n_err + 1;
         last_err_cyc = cyc;
      end
      if (ql_byte_valid) n_valid = n_valid + 1;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic spi_write(input logic [31:0] a, input logic [7:0] d, input bit accepted);
      spi_addr  = a;
      spi_wdata = d;
      spi_wr    = 1'b1;
      tick();
      spi_wr = 1'b0;
      tick();
      if (accepted && a[31:24] == 8'hF3) begin
         model_mem[a[9:0]]   = d;
         model_known[a[9:0]] = 1'b1;
      end
   endtask

   task automatic ack(input logic [7:0] st, input logic [7:0] lo, input logic [7:0] hi);
      spi_write(32'hF400_0000, st, 1'b0);
      spi_write(32'hF400_0001, lo, 1'b0);
      spi_write(32'hF400_0002, hi, 1'b0);
   endtask

   task automatic start_request(input logic [7:0] t);
      ql_req      = 1'b1;
      ql_req_type = t;
      tick();
      ql_req = 1'b0;
      tick();
   endtask

   task automatic drain(input int max_bytes, input int budget, output bit timed_out);
      int left;
      left = budget;
      timed_out = 1'b0;
      while (ql_busy && rx_q.size() < max_bytes && left > 0) begin
         if (ql_byte_valid) begin
            if ($urandom_range(0, 3) != 0) begin
               rx_q.push_back(ql_byte);
               ql_pop = 1'b1;
            end
         end else begin
            ql_pop = 1'($urandom_range(0, 1));
         end
         tick();
         ql_pop = 1'b0;
         left--;
      end
      if (left == 0 && ql_busy && rx_q.size() < max_bytes) timed_out = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      n_cmp++;
      if ({ql_busy, mdv_req, ql_byte_valid, ql_done, ql_error, ql_byte, mdv_req_type, spi_rdata} !== 29'h0) begin
         n_fail++;
         $display("[TB] FAIL reset_outputs: got busy=%b req=%b valid=%b done=%b err=%b byte=%h type=%h rdata=%h, want all 0",
                  ql_busy, mdv_req, ql_byte_valid, ql_done, ql_error, ql_byte, mdv_req_type, spi_rdata);
      end
      reset = 1'b0;
      repeat (2) tick();
      n_cmp++;
      if (ql_busy !== 1'b0 || n_req !== 0) begin
         n_fail++;
         $display("[TB] FAIL idle_after_reset: got busy=%b reqs=%0d, want 0 0", ql_busy, n_req);
      end
   endtask

   task automatic test_read_sector();
      int r0 = n_req;
      int d0 = n_done;
      bit to;
      logic [7:0] exp_rd;
      start_request(8'h02);
      n_cmp++;
      if (n_req - r0 !== 1 || last_req_type !== 8'h02) begin
         n_fail++;
         $display("[TB] FAIL read_req_pulse: got %0d cycles type %h, want 1 cycle type 02", n_req - r0, last_req_type);
      end
      for (int i = 0; i < 10; i++) spi_write(32'hF300_0000 + i, 8'(i), 1'b1);
      spi_addr = 32'hF300_0003;
      tick();
`ifdef MDV_WRITE_EN
      exp_rd = model_mem[3];
`else
      exp_rd = 8'h00;
`endif
      n_cmp++;
      if (spi_rdata !== exp_rd) begin
         n_fail++;
         $display("[TB] FAIL read_spi_rdata: got %h want %h", spi_rdata, exp_rd);
      end
      n_cmp++;
      if (mdv_req_type !== 8'h02) begin
         n_fail++;
         $display("[TB] FAIL req_type_hold: got %h want 02", mdv_req_type);
      end
      ack(8'h00, 8'h0A, 8'h00);
      rx_q.delete();
      drain(2000, 300, to);
      n_cmp++;
      if (to || rx_q.size() !== 10) begin
         n_fail++;
         $display("[TB] FAIL read_count: got %0d bytes (timeout=%0d) want 10", rx_q.size(), to);
      end
      for (int i = 0; i < rx_q.size() && i < 10; i++) begin
         n_cmp++;
         if (rx_q[i] !== 8'(i)) begin
            n_fail++;
            $display("[TB] FAIL read_byte[%0d]: got %h want %h", i, rx_q[i], 8'(i));
         end
      end
      n_cmp++;
      if (n_done - d0 !== 1 || ql_busy !== 1'b0 || ql_byte_valid !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL read_done: got done=%0d busy=%b valid=%b want 1 0 0", n_done - d0, ql_busy, ql_byte_valid);
      end
   endtask

   task automatic test_error_status();
      int e0 = n_err;
      int d0 = n_done;
      int v0 = n_valid;
      start_request(8'h01);
      ack(8'h05, 8'h0A, 8'h00);
      repeat (4) tick();
      n_cmp++;
      if (n_err - e0 !== 1 || n_done - d0 !== 0 || n_valid - v0 !== 0 || ql_busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL error_status: got err=%0d done=%0d valid_cycles=%0d busy=%b want 1 0 0 0",
                  n_err - e0, n_done - d0, n_valid - v0, ql_busy);
      end
   endtask

   task automatic test_timeout();
      int e0 = n_err;
      int d0 = n_done;
      int waited = 0;
      start_request(8'h02);
      while (n_err == e0 && waited < 300) begin
         tick();
         waited++;
      end
      n_cmp++;
      if (n_err == e0) begin
         n_fail++;
         $display("[TB] FAIL timeout_fired: got no error within %0d cycles, want error", waited);
      end
      n_cmp++;
      if (last_err_cyc - last_req_cyc !== 128) begin
         n_fail++;
         $display("[TB] FAIL timeout_latency: got %0d cycles want 128", last_err_cyc - last_req_cyc);
      end
      spi_write(32'hF300_0000, 8'hEE, 1'b0);
      ack(8'h00, 8'h05, 8'h00);
      repeat (3) tick();
      n_cmp++;
      if (ql_busy !== 1'b0 || n_done - d0 !== 0 || n_err - e0 !== 1) begin
         n_fail++;
         $display("[TB] FAIL timeout_ignore: got busy=%b done=%0d err=%0d want 0 0 1", ql_busy, n_done - d0, n_err - e0);
      end
   endtask

   task automatic test_len_zero();
      int d0 = n_done;
      int v0 = n_valid;
      start_request(8'h02);
      ack(8'h00, 8'h00, 8'h00);
      repeat (3) tick();
      n_cmp++;
      if (n_done - d0 !== 1 || n_valid - v0 !== 0 || ql_busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL len_zero: got done=%0d valid_cycles=%0d busy=%b want 1 0 0", n_done - d0, n_valid - v0, ql_busy);
      end
   endtask

   task automatic test_len_clamp();
      int d0 = n_done;
      int bad = 0;
      bit to;
      start_request(8'h02);
      ack(8'h00, 8'hD0, 8'h07);
      rx_q.delete();
      drain(4000, 6000, to);
      n_cmp++;
      if (to || rx_q.size() !== DEPTH) begin
         n_fail++;
         $display("[TB] FAIL clamp_count: got %0d bytes (timeout=%0d) want %0d", rx_q.size(), to, DEPTH);
      end
      for (int i = 0; i < rx_q.size() && i < DEPTH; i++) begin
         if (model_known[i] && rx_q[i] !== model_mem[i]) bad++;
      end
      n_cmp++;
      if (bad !== 0) begin
         n_fail++;
         $display("[TB] FAIL clamp_data: got %0d wrong bytes want 0", bad);
      end
      n_cmp++;
      if (n_done - d0 !== 1) begin
         n_fail++;
         $display("[TB] FAIL clamp_done: got %0d want 1", n_done - d0);
      end
   endtask

   task automatic test_wrap();
      bit to;
      start_request(8'h02);
      spi_write(32'hF300_0400, 8'h5A, 1'b1);
      spi_write(32'hF3AB_CC01, 8'h3C, 1'b1);
      spi_write(32'hF300_0002, 8'h77, 1'b1);
      ack(8'h00, 8'h03, 8'h00);
      rx_q.delete();
      drain(2000, 300, to);
      n_cmp++;
      if (to || rx_q.size() !== 3 || rx_q[0] !== 8'h5A || rx_q[1] !== 8'h3C || rx_q[2] !== 8'h77) begin
         n_fail++;
         $display("[TB] FAIL wrap: got %0d bytes first=%h want 3 bytes 5A 3C 77", rx_q.size(),
                  (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 8; it++) begin
         int n;
         int d0;
         int bad;
         bit to;
         logic [7:0] t;
         logic [31:0] a;
         n  = $urandom_range(1, 24);
         t  = 8'($urandom_range(1, 3));
         d0 = n_done;
         bad = 0;
         start_request(t);
         n_cmp++;
         if (last_req_type !== t) begin
            n_fail++;
            $display("[TB] FAIL rand_type[%0d]: got %h want %h", it, last_req_type, t);
         end
         for (int i = 0; i < n; i++) begin
            a = {8'hF3, 14'($urandom), 10'(i)};
            spi_write(a, 8'($urandom), 1'b1);
            if ($urandom_range(0, 3) == 0) spi_write({8'hF5, 24'($urandom)}, 8'($urandom), 1'b0);
         end
         ack(8'h00, 8'(n), 8'h00);
         rx_q.delete();
         drain(2000, 400, to);
         for (int i = 0; i < rx_q.size() && i < n; i++) begin
            if (rx_q[i] !== model_mem[i]) bad++;
         end
         n_cmp++;
         if (to || rx_q.size() !== n || bad !== 0 || n_done - d0 !== 1) begin
            n_fail++;
            $display("[TB] FAIL rand_sector[%0d]: got %0d bytes, %0d wrong, done=%0d want %0d bytes, 0 wrong, done=1",
                     it, rx_q.size(), bad, n_done - d0, n);
         end
      end
   endtask

   task automatic test_back_to_back();
      int r0 = n_req;
      int d0 = n_done;
      ql_req      = 1'b1;
      ql_req_type = 8'h01;
      tick();
      tick();
      repeat (3) tick();
      n_cmp++;
      if (n_req - r0 !== 1) begin
         n_fail++;
         $display("[TB] FAIL req_ignored_in_fill: got %0d requests want 1", n_req - r0);
      end
      ack(8'h00, 8'h00, 8'h00);
      ql_req = 1'b0;
      tick();
      n_cmp++;
      if (n_req - r0 !== 2 || n_done - d0 !== 1 || ql_busy !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL held_req_restart: got req=%0d done=%0d busy=%b want 2 1 1", n_req - r0, n_done - d0, ql_busy);
      end
      ack(8'h00, 8'h00, 8'h00);
      tick();
      n_cmp++;
      if (n_done - d0 !== 2 || ql_busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL second_done: got done=%0d busy=%b want 2 0", n_done - d0, ql_busy);
      end
   endtask

   task automatic test_reset_mid_drain();
      int d0;
      int e0;
      bit to;
      start_request(8'h02);
      for (int i = 0; i < 8; i++) spi_write(32'hF300_0000 + i, 8'(8'h40 + i), 1'b1);
      ack(8'h00, 8'h08, 8'h00);
      rx_q.delete();
      drain(3, 200, to);
      d0 = n_done;
      e0 = n_err;
      reset = 1'b1;
      #1;
      n_cmp++;
      if ({ql_busy, mdv_req, ql_byte_valid, ql_done, ql_error, ql_byte, mdv_req_type, spi_rdata} !== 29'h0) begin
         n_fail++;
         $display("[TB] FAIL mid_drain_reset: got busy=%b valid=%b byte=%h type=%h want all 0",
                  ql_busy, ql_byte_valid, ql_byte, mdv_req_type);
      end
      tick();
      reset = 1'b0;
      repeat (2) tick();
      n_cmp++;
      if (n_done !== d0 || n_err !== e0 || ql_busy !== 1'b0 || rx_q.size() !== 3) begin
         n_fail++;
         $display("[TB] FAIL abort_no_pulse: got done=%0d err=%0d busy=%b popped=%0d want 0 0 0 3",
                  n_done - d0, n_err - e0, ql_busy, rx_q.size());
      end
      start_request(8'h02);
      spi_write(32'hF300_0000, 8'h91, 1'b1);
      spi_write(32'hF300_0001, 8'h92, 1'b1);
      ack(8'h00, 8'h02, 8'h00);
      rx_q.delete();
      drain(2000, 200, to);
      n_cmp++;
      if (to || rx_q.size() !== 2 || rx_q[0] !== 8'h91 || rx_q[1] !== 8'h92 || n_done - d0 !== 1) begin
         n_fail++;
         $display("[TB] FAIL after_reset_sector: got %0d bytes done=%0d want 2 bytes 91 92 done=1", rx_q.size(), n_done - d0);
      end
   endtask

`ifdef MDV_WRITE_EN
   task automatic test_write_path();
      logic [7:0] vals [4];
      int d0 = n_done;
      int v0 = n_valid;
      vals = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      for (int i = 0; i < 4; i++) begin
         ql_wdata = vals[i];
         ql_wr    = 1'b1;
         tick();
         ql_wr = 1'b0;
         model_mem[i]   = vals[i];
         model_known[i] = 1'b1;
      end
      start_request(8'h03);
      for (int i = 0; i < 4; i++) begin
         spi_addr = 32'hF300_0000 + i;
         tick();
         n_cmp++;
         if (spi_rdata !== vals[i]) begin
            n_fail++;
            $display("[TB] FAIL readback[%0d]: got %h want %h", i, spi_rdata, vals[i]);
         end
      end
      ack(8'h00, 8'h00, 8'h80);
      repeat (3) tick();
      n_cmp++;
      if (n_done - d0 !== 1 || n_valid - v0 !== 0 || ql_busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL write_ack: got done=%0d valid_cycles=%0d busy=%b want 1 0 0", n_done - d0, n_valid - v0, ql_busy);
      end
   endtask
`endif

   initial begin
      for (int i = 0; i < DEPTH; i++) model_known[i] = 1'b0;
      test_reset();
      test_read_sector();
      test_error_status();
      test_timeout();
      test_len_zero();
      test_len_clamp();
      test_wrap();
      test_random();
      test_back_to_back();
      test_reset_mid_drain();
`ifdef MDV_WRITE_EN
      test_write_path();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
